data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 185 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: RV32I load/store access to an internal word RAM with a fixed wait-state latency.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them down.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam bit          HAS_WAIT  = (WAIT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q;

    logic        req_ready_d, rsp_valid_d, rsp_err_d;
    logic [31:0] rsp_rdata_d;
    logic        accept, enter_resp, mem_we;

    logic        cur_we;
    logic [2:0]  cur_funct3;
    logic [31:0] cur_addr, cur_wdata;
    logic        is_half, is_word, f3_bad, oob, misalign, acc_err;
    logic [1:0]  off;
    logic [AW-1:0] idx;
    logic [31:0] rd_word, rd_shift, load_data, wr_shift, wr_word;
    logic [3:0]  byte_en;

    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    // Access decode; with no wait states the response is formed from the live request.
    always_comb begin
        cur_we     = we_q;
        cur_funct3 = funct3_q;
        cur_addr   = addr_q;
        cur_wdata  = wdata_q;
        if (state_q == IDLE) begin
            cur_we     = req_we;
            cur_funct3 = req_funct3;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
        end

        is_half = (cur_funct3[1:0] == 2'b01);
        is_word = (cur_funct3[1:0] == 2'b10);
        f3_bad  = cur_we ? (cur_funct3[2] || (cur_funct3[1:0] == 2'b11))
                         : ((cur_funct3[1:0] == 2'b11) || (cur_funct3[2:1] == 2'b11));
        oob     = (cur_addr[31:2] >= 30'(DEPTH_WORDS));
        off     = cur_addr[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (is_half && cur_addr[0]) || (is_word && (cur_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
        if (is_word) begin
            off = 2'b00;
        end else if (is_half) begin
            off[0] = 1'b0;
        end
`endif
        acc_err = f3_bad || oob || misalign;

        idx      = cur_addr[AW+1:2];
        rd_word  = mem[idx];
        rd_shift = rd_word >> {off, 3'b000};

        case (cur_funct3)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_shift[7:0]};
            3'b101:  load_data = {16'd0, rd_shift[15:0]};
            default: load_data = '0;
        endcase

        case (cur_funct3[1:0])
            2'b00:   byte_en = 4'b0001 << off;
            2'b01:   byte_en = 4'b0011 << off;
            default: byte_en = 4'b1111;
        endcase

        wr_shift = cur_wdata << {off, 3'b000};
        wr_word  = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                wr_word[8*i +: 8] = wr_shift[8*i +: 8];
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        accept      = 1'b0;
        enter_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (HAS_WAIT) begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    wait_cnt_d = '0;
                    enter_resp = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = enter_resp;
        rsp_err_d   = enter_resp && acc_err;
        rsp_rdata_d = (enter_resp && !acc_err && !cur_we) ? load_data : '0;
        // Gating with reset keeps an accept during reset from reaching the RAM.
        mem_we      = enter_resp && cur_we && !acc_err && reset;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            req_ready  <= req_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rsp_rdata_d;
            rsp_err    <= rsp_err_d;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: byte-level memory model, directed cases then random traffic.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WC    = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    logic [7:0] mbytes [DEPTH*4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Reference model on a little-endian byte array.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        int unsigned size;
        logic [31:0] ea;
        logic [31:0] v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err   = we ? (f3 > 3'd2) : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        rdata = '0;
        if ((addr >> 2) >= DEPTH) err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((addr % size) != 0) err = 1'b1;
        ea = addr;
`else
        ea = addr - (addr % size);
`endif
        if (err) return;
        if (we) begin
            for (int i = 0; i < int'(size); i++) mbytes[ea + 32'(i)] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < int'(size); i++) v = v | (32'(mbytes[ea + 32'(i)]) << (8*i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
            rdata = v;
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        logic [31:0] r;
        logic er;
        int w;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        model(we, f3, addr, wdata, r, er);
        e.rdata = r;
        e.err   = er;
        e.cyc   = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Junk request held while busy must be ignored, including in the response cycle.
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        repeat (WC + 1) @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && rsp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%08h, want no response", rsp_rdata);
            end else begin
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("latency", cyc - e.cyc, 32'(WC + 1));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < int'(DEPTH*4); i++) mbytes[i] = 8'h00;

        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;

        issue(1'b1, 3'b010, 32'h10, 32'h8765_4321);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        issue(1'b0, 3'b000, 32'h13, 32'h0);
        issue(1'b0, 3'b100, 32'h13, 32'h0);
        issue(1'b0, 3'b001, 32'h12, 32'h0);
        issue(1'b0, 3'b101, 32'h10, 32'h0);
        issue(1'b1, 3'b000, 32'h11, 32'hFFFF_FFAA);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        issue(1'b1, 3'b001, 32'h12, 32'h1234_BEEF);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        issue(1'b0, 3'b010, 32'h400, 32'h0);
        issue(1'b1, 3'b011, 32'h10, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        issue(1'b0, 3'b010, 32'h12, 32'h0);
        issue(1'b0, 3'b001, 32'h11, 32'h0);
        issue(1'b0, 3'b011, 32'h10, 32'h0);
        issue(1'b0, 3'b110, 32'h10, 32'h0);
        issue(1'b1, 3'b010, 32'h3FC, 32'hCAFE_F00D);
        issue(1'b0, 3'b010, 32'h3FC, 32'h0);

        // Reset while a store is waiting: it must neither write nor respond.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h1234_5678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("midop_req_ready", 32'(req_ready), 32'd1);
        check("midop_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midop_rsp_rdata", rsp_rdata, 32'd0);
        check("midop_rsp_err", 32'(rsp_err), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (4) @(posedge clk);
        issue(1'b0, 3'b010, 32'h20, 32'h0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = $urandom_range(0, DEPTH*4 - 1);
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) check("drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
